// File: rtl/addsub_pipe_if.sv
// addsub_pipe_if: operand/result handshake bundle for addsub_pipe.
//   master: drives operands (in_*) and out_ready, observes in_ready and results.
//   slave : the adder pipeline itself.
//   in_valid/in_ready, in_a/in_b, in_op (00 ADD, 01 SUB, 10 ADC, 11 SBB), in_cin
//   out_valid/out_ready, out_sum, out_n/out_z/out_c/out_v
// Optional: ADDSUB_SAT_EN adds in_sat (request clamp) and out_sat (clamp applied).
interface addsub_pipe_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [1:0]       in_op;
  logic             in_cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_n;
  logic             out_z;
  logic             out_c;
  logic             out_v;
`ifdef ADDSUB_SAT_EN
  logic             in_sat;
  logic             out_sat;

  modport master (
    output in_valid, in_a, in_b, in_op, in_cin, in_sat, out_ready,
    input  in_ready, out_valid, out_sum, out_n, out_z, out_c, out_v, out_sat
  );
  modport slave (
    input  in_valid, in_a, in_b, in_op, in_cin, in_sat, out_ready,
    output in_ready, out_valid, out_sum, out_n, out_z, out_c, out_v, out_sat
  );
`else
  modport master (
    output in_valid, in_a, in_b, in_op, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_n, out_z, out_c, out_v
  );
  modport slave (
    input  in_valid, in_a, in_b, in_op, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_n, out_z, out_c, out_v
  );
`endif
endinterface

// File: rtl/addsub_pipe.sv
// addsub_pipe: skewed pipelined adder/subtractor with NZCV flags.
// Each of STAGES stages adds WIDTH/STAGES bits using 4-bit carry-lookahead groups;
// the carry between segments is registered. Valid/ready with full backpressure.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : addsub_pipe_if.slave (operands in, result + flags out)
// Optional feature macro ADDSUB_SAT_EN: per-op signed saturation (in_sat/out_sat).
module addsub_pipe #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 2
) (
  input logic           clk,
  input logic           rst_n,
  addsub_pipe_if.slave  bus
);
  localparam int unsigned SegW   = WIDTH / STAGES;
  localparam int unsigned NumGrp = SegW / 4;
  localparam int unsigned Last   = STAGES - 1;

  localparam logic [1:0] OpAdd = 2'b00;
  localparam logic [1:0] OpSub = 2'b01;
  localparam logic [1:0] OpAdc = 2'b10;
  localparam logic [1:0] OpSbb = 2'b11;

  logic [STAGES-1:0] vld_q, vld_d, acc, v_in;
  logic [STAGES:0]   rdy;
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  a_d [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  b_d [STAGES];
  logic [WIDTH-1:0]  sum_q [STAGES];
  logic [WIDTH-1:0]  sum_d [STAGES];
  logic [WIDTH-1:0]  a_in [STAGES];
  logic [WIDTH-1:0]  b_in [STAGES];
  logic [WIDTH-1:0]  s_in [STAGES];
  logic [STAGES-1:0] c_in, cy_q, cy_d;
  // Carry into the result MSB, only meaningful for the final segment.
  logic              cm_q, cm_d;
  logic [WIDTH-1:0]  b_eff;
  logic              cin0;
  logic              ovf;
  logic [WIDTH-1:0]  res;
`ifdef ADDSUB_SAT_EN
  logic [STAGES-1:0] sat_in, sat_q, sat_d;
  logic              clamp;
`endif

  // Operand conditioning: subtract is a + ~b + 1, borrow-in inverts the carry.
  always_comb begin
    b_eff = bus.in_b;
    cin0  = 1'b0;
    unique case (bus.in_op)
      OpAdd: begin b_eff = bus.in_b;  cin0 = 1'b0;        end
      OpSub: begin b_eff = ~bus.in_b; cin0 = 1'b1;        end
      OpAdc: begin b_eff = bus.in_b;  cin0 = bus.in_cin;  end
      OpSbb: begin b_eff = ~bus.in_b; cin0 = ~bus.in_cin; end
      default: ;
    endcase
  end

  // Stage inputs: stage 0 from the bus, stage k from stage k-1 registers.
  always_comb begin
    a_in[0] = bus.in_a;
    b_in[0] = b_eff;
    s_in[0] = '0;
    c_in[0] = cin0;
    v_in[0] = bus.in_valid;
`ifdef ADDSUB_SAT_EN
    sat_in[0] = bus.in_sat;
`endif
    for (int k = 1; k < int'(STAGES); k++) begin
      a_in[k] = a_q[k-1];
      b_in[k] = b_q[k-1];
      s_in[k] = sum_q[k-1];
      c_in[k] = cy_q[k-1];
      v_in[k] = vld_q[k-1];
`ifdef ADDSUB_SAT_EN
      sat_in[k] = sat_q[k-1];
`endif
    end
  end

  // Ready ripples back from out_ready; an empty stage always accepts.
  always_comb begin
    rdy    = '0;
    acc    = '0;
    vld_d  = '0;
    rdy[STAGES] = bus.out_ready;
    for (int k = int'(STAGES) - 1; k >= 0; k--) begin
      rdy[k]   = ~vld_q[k] | rdy[k+1];
      acc[k]   = v_in[k] & rdy[k];
      vld_d[k] = acc[k] | (vld_q[k] & ~rdy[k+1]);
    end
  end

  // Segment k adds bits [k*SegW +: SegW]; group carries use 4-bit G/P lookahead.
  always_comb begin
    logic [WIDTH-1:0] s;
    logic [3:0]       gg, pp;
    logic             c, cb, cm, cm_last, grp_g, grp_p;
    int               base;
    cm_last = 1'b0;
    for (int k = 0; k < int'(STAGES); k++) begin
      s  = s_in[k];
      c  = c_in[k];
      cm = 1'b0;
      for (int j = 0; j < int'(NumGrp); j++) begin
        base  = k * int'(SegW) + j * 4;
        gg    = a_in[k][base +: 4] & b_in[k][base +: 4];
        pp    = a_in[k][base +: 4] ^ b_in[k][base +: 4];
        grp_g = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1]) |
                (pp[3] & pp[2] & pp[1] & gg[0]);
        grp_p = &pp;
        cb    = c;
        for (int t = 0; t < 4; t++) begin
          s[base+t] = pp[t] ^ cb;
          cm        = cb;
          cb        = gg[t] | (pp[t] & cb);
        end
        c = grp_g | (grp_p & c);
      end
      cm_last  = cm;
      a_d[k]   = acc[k] ? a_in[k] : a_q[k];
      b_d[k]   = acc[k] ? b_in[k] : b_q[k];
      sum_d[k] = acc[k] ? s       : sum_q[k];
      cy_d[k]  = acc[k] ? c       : cy_q[k];
`ifdef ADDSUB_SAT_EN
      sat_d[k] = acc[k] ? sat_in[k] : sat_q[k];
`endif
    end
    cm_d = acc[Last] ? cm_last : cm_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      cy_q  <= '0;
      cm_q  <= 1'b0;
`ifdef ADDSUB_SAT_EN
      sat_q <= '0;
`endif
      for (int k = 0; k < int'(STAGES); k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        sum_q[k] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      cy_q  <= cy_d;
      cm_q  <= cm_d;
`ifdef ADDSUB_SAT_EN
      sat_q <= sat_d;
`endif
      for (int k = 0; k < int'(STAGES); k++) begin
        a_q[k]   <= a_d[k];
        b_q[k]   <= b_d[k];
        sum_q[k] <= sum_d[k];
      end
    end
  end

  // Flags from the final stage; overflow = carry into MSB xor carry out of MSB.
  always_comb begin
    ovf = cm_q ^ cy_q[Last];
    res = sum_q[Last];
`ifdef ADDSUB_SAT_EN
    // On overflow both operand MSBs agree, so a's MSB picks the clamp direction.
    clamp = sat_q[Last] & ovf;
    if (clamp) res = {a_q[Last][WIDTH-1], {(WIDTH-1){~a_q[Last][WIDTH-1]}}};
`endif
  end

  assign bus.in_ready  = rdy[0];
  assign bus.out_valid = vld_q[Last];
  assign bus.out_sum   = res;
  assign bus.out_n     = res[WIDTH-1];
  assign bus.out_z     = (res == '0);
  assign bus.out_c     = cy_q[Last];
  assign bus.out_v     = ovf;
`ifdef ADDSUB_SAT_EN
  assign bus.out_sat   = clamp;
`endif

endmodule

// File: tb/tb_addsub_pipe.sv
// tb_addsub_pipe: scoreboard bench for addsub_pipe. Four instances (STAGES 2, 1, 4, 8,
// WIDTH 32) receive identical stimulus and are released in lockstep; each has its own
// monitor walking the shared expected-result queue.
module tb_addsub_pipe;
  localparam logic [1:0] OpAdd = 2'b00;
  localparam logic [1:0] OpSub = 2'b01;
  localparam logic [1:0] OpAdc = 2'b10;
  localparam logic [1:0] OpSbb = 2'b11;
`ifdef ADDSUB_SAT_EN
  localparam bit SatEn = 1'b1;
`else
  localparam bit SatEn = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] sum;
    logic        n;
    logic        z;
    logic        c;
    logic        v;
    logic        sat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        drv_valid;
  logic [31:0] drv_a, drv_b;
  logic [1:0]  drv_op;
  logic        drv_cin, drv_sat;
  logic        out_ready;
  logic        all_ready;
  logic        done, stop;
  int          n_tests = 0;
  int          n_fail  = 0;
  exp_t        exp_q[$];

  always #5 clk = ~clk;

  addsub_pipe_if #(.WIDTH(32)) bus [4] ();

  for (genvar i = 0; i < 4; i++) begin : g_mon
    localparam int unsigned St = (i == 0) ? 2 : (i == 1) ? 1 : (i == 2) ? 4 : 8;
    int   rd_idx = 0;
    exp_t obs;

    addsub_pipe #(.WIDTH(32), .STAGES(St)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus[i])
    );

    assign bus[i].in_valid  = drv_valid;
    assign bus[i].in_a      = drv_a;
    assign bus[i].in_b      = drv_b;
    assign bus[i].in_op     = drv_op;
    assign bus[i].in_cin    = drv_cin;
    assign bus[i].out_ready = out_ready;
`ifdef ADDSUB_SAT_EN
    assign bus[i].in_sat = drv_sat;
    assign obs = {bus[i].out_sum, bus[i].out_n, bus[i].out_z, bus[i].out_c, bus[i].out_v,
                  bus[i].out_sat};
`else
    assign obs = {bus[i].out_sum, bus[i].out_n, bus[i].out_z, bus[i].out_c, bus[i].out_v,
                  1'b0};
`endif

    // In-flight operations are discarded by reset.
    always @(negedge rst_n) rd_idx = exp_q.size();

    always @(negedge clk) begin
      if (rst_n && bus[i].out_valid && bus[i].out_ready) begin
        n_tests++;
        if (rd_idx >= exp_q.size()) begin
          n_fail++;
          $display("FAIL result_unexpected[S%0d] got=%h want=none", St, obs);
        end else begin
          if (obs !== exp_q[rd_idx]) begin
            n_fail++;
            $display("FAIL result[S%0d] op#%0d got sum=%h nzcvs=%b want sum=%h nzcvs=%b",
                     St, rd_idx, obs.sum, {obs.n, obs.z, obs.c, obs.v, obs.sat},
                     exp_q[rd_idx].sum,
                     {exp_q[rd_idx].n, exp_q[rd_idx].z, exp_q[rd_idx].c, exp_q[rd_idx].v,
                      exp_q[rd_idx].sat});
          end
          rd_idx++;
        end
      end
    end

    always @(posedge done) begin
      n_tests++;
      if (rd_idx != exp_q.size()) begin
        n_fail++;
        $display("FAIL drained[S%0d] got=%0d results want=%0d", St, rd_idx, exp_q.size());
      end
    end
  end

  assign all_ready = bus[0].in_ready & bus[1].in_ready & bus[2].in_ready & bus[3].in_ready;

  function automatic exp_t mk(input logic [31:0] s, input logic n, z, c, v, sat);
    exp_t e;
    e.sum = s; e.n = n; e.z = z; e.c = c; e.v = v; e.sat = sat;
    return e;
  endfunction

  // Reference: plain 33-bit add of conditioned operands, sign-rule overflow.
  function automatic exp_t model(input logic [31:0] a, b, input logic [1:0] op,
                                 input logic cin, sat);
    exp_t        e;
    logic [31:0] be;
    logic        ci;
    logic [32:0] r;
    be = op[0] ? ~b : b;
    case (op)
      OpAdd:   ci = 1'b0;
      OpSub:   ci = 1'b1;
      OpAdc:   ci = cin;
      default: ci = ~cin;
    endcase
    r     = {1'b0, a} + {1'b0, be} + {32'd0, ci};
    e.c   = r[32];
    e.v   = (a[31] == be[31]) && (r[31] != a[31]);
    e.sum = r[31:0];
    e.sat = sat && e.v && SatEn;
    if (e.sat) e.sum = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    e.n = e.sum[31];
    e.z = (e.sum == 32'd0);
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] got, want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // Presents one op at a negedge once every instance is ready; transfer at next posedge.
  task automatic send_exp(input logic [31:0] a, b, input logic [1:0] op,
                          input logic cin, sat, input exp_t e);
    int w;
    drv_a = a; drv_b = b; drv_op = op; drv_cin = cin; drv_sat = sat;
    w = 0;
    @(negedge clk);
    while (!all_ready && w < 50) begin
      w++;
      @(negedge clk);
    end
    if (!all_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout got in_ready=0 want 1 within 50 cycles");
    end else begin
      drv_valid = 1'b1;
      exp_q.push_back(e);
      @(posedge clk);
      #1 drv_valid = 1'b0;
    end
  endtask

  task automatic send_ref(input logic [31:0] a, b, input logic [1:0] op, input logic cin, sat);
    send_exp(a, b, op, cin, sat, model(a, b, op, cin, sat));
  endtask

  initial begin
    int          lat [4];
    exp_t        snap;
    logic [31:0] ra, rb;
    rst_n = 1'b0; drv_valid = 1'b0; drv_a = '0; drv_b = '0; drv_op = OpAdd;
    drv_cin = 1'b0; drv_sat = 1'b0; out_ready = 1'b1; done = 1'b0; stop = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(bus[0].out_valid), 64'd0);
    check("rst_in_ready", 64'(bus[0].in_ready), 64'd1);
    check("rst_outputs", 64'(g_mon[0].obs), 64'(mk(32'd0, 0, 1, 0, 0, 0)));
    check("rst_out_valid_s8", 64'(bus[3].out_valid), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Latency from an empty pipe, counted in edges including the capture edge.
    send_exp(32'hFFFF_FFFF, 32'h1, OpAdd, 1'b0, 1'b0, mk(32'd0, 0, 1, 1, 0, 0));
    lat = '{default: 0};
    for (int cyc = 1; cyc <= 10; cyc++) begin
      if (lat[0] == 0 && bus[0].out_valid) lat[0] = cyc;
      if (lat[1] == 0 && bus[1].out_valid) lat[1] = cyc;
      if (lat[2] == 0 && bus[2].out_valid) lat[2] = cyc;
      if (lat[3] == 0 && bus[3].out_valid) lat[3] = cyc;
      @(posedge clk); #1;
    end
    check("latency_s2", 64'(lat[0]), 64'd2);
    check("latency_s1", 64'(lat[1]), 64'd1);
    check("latency_s4", 64'(lat[2]), 64'd4);
    check("latency_s8", 64'(lat[3]), 64'd8);

    // Directed vectors, back to back.
    send_exp(32'h8000_0000, 32'h1, OpSub, 1'b0, 1'b0, mk(32'h7FFF_FFFF, 0, 0, 1, 1, 0));
    send_exp(32'h0, 32'h0, OpAdc, 1'b1, 1'b0, mk(32'h1, 0, 0, 0, 0, 0));
    send_exp(32'h5, 32'h3, OpSbb, 1'b0, 1'b0, mk(32'h2, 0, 0, 1, 0, 0));
    send_exp(32'h7FFF_FFFF, 32'h1, OpAdd, 1'b0, 1'b0, mk(32'h8000_0000, 1, 0, 0, 1, 0));
    send_exp(32'h3, 32'h5, OpSub, 1'b0, 1'b0, mk(32'hFFFF_FFFE, 1, 0, 0, 0, 0));
    send_exp(32'h1234_5678, 32'h9ABC_DEF0, OpAdd, 1'b0, 1'b0,
             mk(32'hACF1_3568, 1, 0, 0, 0, 0));
    send_exp(32'h0, 32'h0, OpSbb, 1'b1, 1'b0, mk(32'hFFFF_FFFF, 1, 0, 0, 0, 0));
    send_exp(32'h7FFF_FFFF, 32'h0, OpAdc, 1'b1, 1'b0, mk(32'h8000_0000, 1, 0, 0, 1, 0));
    send_exp(32'h5, 32'h5, OpSub, 1'b0, 1'b0, mk(32'h0, 0, 1, 1, 0, 0));
    send_exp(32'h1, 32'h1, OpAdd, 1'b1, 1'b0, mk(32'h2, 0, 0, 0, 0, 0));
    send_exp(32'h0000_FFFF, 32'h1, OpAdd, 1'b0, 1'b0, mk(32'h0001_0000, 0, 0, 0, 0, 0));
    send_exp(32'h0, 32'h1, OpSub, 1'b0, 1'b1, mk(32'hFFFF_FFFF, 1, 0, 0, 0, 0));
`ifdef ADDSUB_SAT_EN
    send_exp(32'h8000_0000, 32'h1, OpSub, 1'b0, 1'b1, mk(32'h8000_0000, 1, 0, 1, 1, 1));
    send_exp(32'h7FFF_FFFF, 32'h1, OpAdd, 1'b0, 1'b1, mk(32'h7FFF_FFFF, 0, 0, 0, 1, 1));
`else
    send_exp(32'h8000_0000, 32'h1, OpSub, 1'b0, 1'b1, mk(32'h7FFF_FFFF, 0, 0, 1, 1, 0));
    send_exp(32'h7FFF_FFFF, 32'h1, OpAdd, 1'b0, 1'b1, mk(32'h8000_0000, 1, 0, 0, 1, 0));
`endif
    repeat (12) @(posedge clk);
    #1;

    // Backpressure: six ops, out_ready low for four cycles once results appear.
    fork
      begin
        for (int i = 0; i < 6; i++)
          send_ref(32'h1111_1111 * i, 32'h0F0F_0F0F + i, 2'(i % 4), 1'(i % 2), 1'b0);
      end
      begin
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check("stall_out_valid", 64'(bus[0].out_valid), 64'd1);
        snap = g_mon[0].obs;
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          check("stall_hold", 64'(g_mon[0].obs), 64'(snap));
        end
        check("stall_in_ready", 64'(bus[0].in_ready), 64'd0);
        check("stall_valid_held", 64'(bus[0].out_valid), 64'd1);
        @(posedge clk);
        #1 out_ready = 1'b1;
        #1 check("unstall_in_ready", 64'(bus[0].in_ready), 64'd1);
      end
    join
    repeat (12) @(posedge clk);
    #1;

    // Asynchronous reset with two ops in flight.
    send_ref(32'd10, 32'd20, OpAdd, 1'b0, 1'b0);
    send_ref(32'd7, 32'd9, OpSub, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(bus[0].out_valid), 64'd0);
    check("midrst_out_valid_s1", 64'(bus[1].out_valid), 64'd0);
    check("midrst_outputs", 64'(g_mon[0].obs), 64'(mk(32'd0, 0, 1, 0, 0, 0)));
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("postrst_in_ready", 64'(bus[0].in_ready), 64'd1);
    send_exp(32'd100, 32'd1, OpSub, 1'b0, 1'b0, mk(32'd99, 0, 0, 1, 0, 0));
    repeat (12) @(posedge clk);
    #1;

    // Mixed operands against the reference with random backpressure.
    fork
      begin
        for (int i = 0; i < 24; i++) begin
          ra = (i % 5 == 0) ? 32'h7FFF_FFFF : $urandom;
          rb = (i % 7 == 0) ? 32'h8000_0000 : $urandom;
          send_ref(ra, rb, 2'($urandom_range(3)), 1'($urandom_range(1)),
                   1'($urandom_range(1)));
        end
        stop = 1'b1;
      end
      begin
        while (!stop) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    repeat (20) @(posedge clk);
    done = 1'b1;
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/addsub_pipe.md
Name: addsub_pipe

Overview:
- Parametrised, pipelined adder/subtractor for the CPU execute path. It is the successor to the fixed 32-bit combinational carry-lookahead adder.
- Operand width is split into STAGES equal segments. Each segment is a 4-bit-group carry-lookahead add, and a carry register sits between segments.
- Supports add, subtract, add-with-carry and subtract-with-borrow, and produces NZCV flags.
- Uses a valid/ready handshake with full backpressure, so the ALU or multi-cycle datapath can stall it.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of STAGES*4.
- STAGES, 2, number of pipeline stages (1..8); each stage adds WIDTH/STAGES bits.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  stage 0 can accept.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_op  input  2  00 ADD, 01 SUB, 10 ADC, 11 SBB.
- in_cin  input  1  carry in for ADC/SBB.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts.
- out_sum  output  WIDTH  result.
- out_n  output  1  negative: out_sum[WIDTH-1].
- out_z  output  1  zero: out_sum == 0.
- out_c  output  1  carry out of MSB (raw adder carry; SUB with no borrow gives 1).
- out_v  output  1  signed overflow.
- out_sat  output  1  saturation applied; present only with ADDSUB_SAT_EN.

Behaviour:
- Operand conditioning happens at stage 0 input:
  - b_eff = in_b inverted for SUB/SBB, otherwise in_b.
  - cin = 0 for ADD, 1 for SUB, in_cin for ADC, ~in_cin for SBB.
- Stage k (0..STAGES-1):
  - Registers segment k of the sum, carry-in from the stage k-1 carry register, generated from 4-bit group generate/propagate lookahead.
  - Carries the not-yet-added upper operand bits forward (skewed pipeline).
  - Carries the already-summed lower result bits forward (deskew).
- Flags are computed combinationally from the final-stage registers:
  - c = final carry register.
  - v = carry into MSB XOR carry out of MSB.
  - z and n derived from the assembled sum.
- Handshake:
  - Per-stage valid bit vld[k].
  - Stage k accepts when !vld[k] || rdy[k+1]; rdy[STAGES] = out_ready.
  - in_ready = !vld[0] || rdy[1], combinational from out_ready through the chain.
  - A transfer occurs on a clk edge with valid && ready at that boundary.
  - out_valid = vld[STAGES-1].
- Latency: a transfer accepted at edge t gives out_valid at edge t+STAGES-1 (i.e. after STAGES edges including the capture) when never stalled. Throughput is 1 op/clk.
- Stall: while out_valid && !out_ready, all output ports hold stable. Bubbles ahead of the stall compress (a stage with vld=0 still accepts).
- Simultaneous accept and drain in the same cycle on a full pipe is allowed; no bubble is inserted.
- Reset (async, any time, including mid-operation):
  - All vld clear immediately; out_valid=0; in_ready=1 after deassert.
  - out_sum=0; out_n=0, out_z=1, out_c=0, out_v=0.
  - In-flight ops are discarded.
- STAGES=1 degenerates to a single registered CLA: latency 1, in_ready = !vld[0] || out_ready.
- Wrap-around: the sum is modulo 2^WIDTH; the carry is reported only via out_c.
- Data registers are not required to reset except the final stage (for the defined output values above). Non-final data registers update only on accept.

Optional Feature:
- Macro: ADDSUB_SAT_EN.
- Defined:
  - Adds input port in_sat (1 bit, sampled with the operands and pipelined alongside them).
  - When in_sat=1 and overflow occurs, out_sum clamps to 0111..1 (positive overflow, operand MSBs were 0) or 1000..0 (negative overflow).
  - out_sat=1 on a clamp; out_v still reports 1.
  - n and z follow the clamped value; c is the raw carry.
- Not defined: in_sat and out_sat ports are absent, and the result always wraps.

Test Plan:
- ADD 0xFFFFFFFF + 0x00000001, WIDTH=32, STAGES=2 -> out_sum=0, z=1, c=1, v=0, n=0, out_valid exactly 2 edges after accept.
- SUB 0x80000000 - 0x00000001 -> out_sum=0x7FFFFFFF, v=1, c=1, n=0; with ADDSUB_SAT_EN and in_sat=1 -> out_sum=0x80000000, out_sat=1.
- ADC chain: low ADD 0xFFFFFFFF+1 (c=1), then ADC 0x00000000+0x00000000 with in_cin=1 -> out_sum=1, c=0; SBB 5-3 in_cin=0 -> 2, c=1.
- Backpressure: issue 6 back-to-back ops with out_ready low for cycles 3-6 -> in_ready drops once STAGES entries are held, no op lost or duplicated, outputs stable while stalled, results in issue order.
- Async reset asserted mid-stream with 2 ops in flight -> out_valid falls without a clock, no stale result appears after release, the first post-reset op completes normally.
- Sweep STAGES=1,4,8 with WIDTH=32 against random operands (reference model a+b_eff+cin) -> bit-exact sums and flags; latency = STAGES.
